// File: rtl/aoi_pipe_pkg.sv
// Shared constants and types for the pipelined AND-OR-INVERT block.
package aoi_pipe_pkg;

    localparam int DEF_N_TERMS = 2;
    localparam int DEF_TERM_W  = 2;
    localparam int DEF_CNT_W   = 16;

    typedef enum logic {
        AO  = 1'b0,
        AOI = 1'b1
    } mode_e;

    // Wide enough for the largest supported term count; sliced at use.
    localparam logic [15:0] MASK_RST = '1;

endpackage

// File: rtl/aoi_pipe_pipe_reg.sv
// Generic valid/ready register stage; refills in the same cycle it drains.
module pipe_reg #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);

    logic         valid_reg;
    logic [W-1:0] data_reg;
    logic         load;

    assign load      = !valid_reg || out_ready;
    assign in_ready  = load;
    assign out_valid = valid_reg;
    assign out_data  = data_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
        end else if (load) begin
            valid_reg <= in_valid;
            if (in_valid) begin
                data_reg <= in_data;
            end
        end
    end

endmodule

// File: rtl/aoi_pipe.sv
// Two-stage pipelined AND-OR(-INVERT) over N_TERMS masked product terms.
// Optional saturating result counter enabled by defining AOI_PIPE_CNT_EN.
module aoi_pipe
    import aoi_pipe_pkg::*;
#(
    parameter int N_TERMS = DEF_N_TERMS,
    parameter int TERM_W  = DEF_TERM_W,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_TERMS*TERM_W-1:0] in_bits,
    input  logic                      in_inv,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      cfg_we,
    input  logic [N_TERMS-1:0]        cfg_mask,
    output logic                      out_f,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CNT_W-1:0]          cnt,
    input  logic                      cnt_clr
);

    logic [N_TERMS-1:0] mask_reg;
    logic [N_TERMS-1:0] and_vec;
    logic [N_TERMS:0]   s1_in_data;
    logic [N_TERMS:0]   s1_data;
    logic               s1_valid;
    logic               s2_in_ready;
    logic               f_next;
    mode_e              s1_mode;

    // An input accepted on the same edge as a mask write sees the old mask.
    always_ff @(posedge clk) begin
        if (rst) begin
            mask_reg <= MASK_RST[N_TERMS-1:0];
        end else if (cfg_we) begin
            mask_reg <= cfg_mask;
        end
    end

    generate
        for (genvar gi = 0; gi < N_TERMS; gi++) begin : g_term
            assign and_vec[gi] = (&in_bits[gi*TERM_W +: TERM_W]) & mask_reg[gi];
        end
    endgenerate

    assign s1_in_data = {in_inv, and_vec};

    pipe_reg #(.W(N_TERMS + 1)) u_s1 (
        .clk       (clk),
        .rst       (rst),
        .in_data   (s1_in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (s1_data),
        .out_valid (s1_valid),
        .out_ready (s2_in_ready)
    );

    assign s1_mode = mode_e'(s1_data[N_TERMS]);
    assign f_next  = (|s1_data[N_TERMS-1:0]) ^ (s1_mode == AOI);

    pipe_reg #(.W(1)) u_s2 (
        .clk       (clk),
        .rst       (rst),
        .in_data   (f_next),
        .in_valid  (s1_valid),
        .in_ready  (s2_in_ready),
        .out_data  (out_f),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

`ifdef AOI_PIPE_CNT_EN
    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            cnt_reg <= '0;
        end else if (out_valid && out_ready && out_f && (cnt_reg != {CNT_W{1'b1}})) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign cnt = cnt_reg;
`else
    logic unused_cnt_clr;

    assign unused_cnt_clr = cnt_clr;
    assign cnt            = '0;
`endif

endmodule
